// File: rtl/piso_design_if.sv
// Parallel-in / serial-out stream bundle: byte write side, bit read side and FIFO status.
interface piso_design_if;
    logic [7:0] data_i;
    logic       valid_i;
    logic       ready_o;
    logic       data_o;
    logic       valid_o;
    logic       ready_i;
    logic       sof_o;
    logic       full_o;
    logic       empty_o;

    modport master (
        output data_i, valid_i, ready_i,
        input  ready_o, data_o, valid_o, sof_o, full_o, empty_o
    );

    modport slave (
        input  data_i, valid_i, ready_i,
        output ready_o, data_o, valid_o, sof_o, full_o, empty_o
    );
endinterface

// File: rtl/piso_design.sv
// Byte FIFO feeding an LSB-first serializer; words stream back-to-back with no idle bit.
module piso_design #(
    parameter int         DEPTH   = 16,
    parameter logic [1:0] S_IDLE  = 2'b01,
    parameter logic [1:0] S_SHIFT = 2'b10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    piso_design_if.slave bus
);
    localparam int         AW         = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          wr_en;
    logic          pop;

    logic [1:0] state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_q, bit_d;

    assign full        = (count == FULL_COUNT);
    assign empty       = (count == '0);
    assign wr_en       = bus.valid_i && !full;
    assign bus.ready_o = !full;
    assign bus.full_o  = full;
    assign bus.empty_o = empty;

    // NOTE: the storage array is deliberately left out of reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr] <= bus.data_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
        end
    end

    // NOTE: hold-value defaults come first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr];
                    bit_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bus.ready_i) begin
                    if (bit_q != 3'd7) begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 3'd1;
                    end else if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr];
                        bit_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.valid_o = (state_q == S_SHIFT);
        bus.data_o  = bus.valid_o && shift_q[0];
        bus.sof_o   = bus.valid_o && (bit_q == 3'd0);
    end
endmodule

// File: tb/tb_piso_design.sv
// Directed bench for piso_design: a reference model queues expected bits on each accepted write and pops them per bit handshake.
module tb_piso_design;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    // Reference model state
    logic exp_q[$];
    int   m_occ   = 0;
    bit   m_shift = 1'b0;
    int   m_bit   = 0;

    piso_design_if bus ();

    piso_design #(.DEPTH(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, compare against the model, then advance it past the rising edge.
    task automatic tick(input logic [7:0] d, input logic v, input logic r, output logic acc);
        bit hs;
        bit pop_m;
        @(negedge clk);
        bus.data_i  = d;
        bus.valid_i = v;
        bus.ready_i = r;
        #1;
        check("ready", bus.ready_o, 32'(m_occ != 16));
        check("full",  bus.full_o,  32'(m_occ == 16));
        check("empty", bus.empty_o, 32'(m_occ == 0));
        check("valid", bus.valid_o, 32'(m_shift));
        if (m_shift) begin
            check("data", bus.data_o, 32'(exp_q[0]));
            check("sof",  bus.sof_o,  32'(m_bit == 0));
        end else begin
            check("idle_data", bus.data_o, 0);
            check("idle_sof",  bus.sof_o,  0);
        end
        acc = v && (m_occ != 16);
        if (acc) for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        hs    = m_shift && r;
        pop_m = 1'b0;
        if (hs) begin
            void'(exp_q.pop_front());
            if (m_bit != 7) m_bit++;
            else if (m_occ > 0) begin
                pop_m = 1'b1;
                m_bit = 0;
            end else m_shift = 1'b0;
        end else if (!m_shift && m_occ > 0) begin
            pop_m   = 1'b1;
            m_shift = 1'b1;
            m_bit   = 0;
        end
        m_occ = m_occ + int'(acc) - int'(pop_m);
        @(posedge clk);
    endtask

    task automatic idle_cycles(input int n, input logic r);
        logic a;
        for (int i = 0; i < n; i++) tick(8'h00, 1'b0, r, a);
    endtask

    task automatic drain();
        logic a;
        int   n = 0;
        while ((m_shift || m_occ > 0) && n < 600) begin
            tick(8'h00, 1'b0, 1'b1, a);
            n++;
        end
        @(negedge clk);
        #1;
        check("drain_valid", bus.valid_o, 0);
        check("drain_empty", bus.empty_o, 1);
        check("drain_queue", 32'(exp_q.size()), 0);
    endtask

    initial begin
        logic a;
        int   n;
        int   i;
        rst         = 1'b1;
        bus.data_i  = '0;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        #3 rst = 1'b0;
        #1;
        check("rst_valid", bus.valid_o, 0);
        check("rst_data",  bus.data_o,  0);
        check("rst_sof",   bus.sof_o,   0);
        check("rst_empty", bus.empty_o, 1);
        check("rst_full",  bus.full_o,  0);
        check("rst_ready", bus.ready_o, 1);
        @(negedge clk);
        rst = 1'b1;

        // Single word A5, sink always ready
        tick(8'hA5, 1'b1, 1'b1, a);
        drain();

        // Back-to-back words: 16 contiguous bits
        tick(8'h01, 1'b1, 1'b1, a);
        tick(8'hFF, 1'b1, 1'b1, a);
        drain();

        // Stall five cycles while bit 3 of 3C is presented
        tick(8'h3C, 1'b1, 1'b1, a);
        idle_cycles(4, 1'b1);
        check("stall_bit", 32'(m_bit), 3);
        idle_cycles(5, 1'b0);
        drain();

        // Fill with sink stalled: 1 word in the shifter plus 16 queued
        for (int k = 0; k < 17; k++) tick(8'(8'h10 + k), 1'b1, 1'b0, a);
        #1;
        check("full_flag",  bus.full_o,  1);
        check("full_ready", bus.ready_o, 0);
        tick(8'hEE, 1'b1, 1'b0, a);
        drain();

        // Wrap-around: 40 incrementing words through a 16-deep FIFO
        i = 0;
        n = 0;
        while (i < 40 && n < 2000) begin
            tick(8'(i), 1'b1, 1'b1, a);
            if (a) i++;
            n++;
        end
        check("wrap_accepted", 32'(i), 40);
        drain();

        // Reset mid-frame at bit 4 with three words queued
        for (int k = 0; k < 4; k++) tick(8'(8'hC0 + k), 1'b1, 1'b1, a);
        n = 0;
        while (!(m_shift && m_bit == 4) && n < 50) begin
            tick(8'h00, 1'b0, 1'b1, a);
            n++;
        end
        check("pre_rst_queued", 32'(m_occ), 3);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", bus.valid_o, 0);
        check("mid_rst_empty", bus.empty_o, 1);
        check("mid_rst_full",  bus.full_o,  0);
        check("mid_rst_ready", bus.ready_o, 1);
        check("mid_rst_sof",   bus.sof_o,   0);
        exp_q.delete();
        m_occ   = 0;
        m_shift = 1'b0;
        m_bit   = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick(8'h81, 1'b1, 1'b1, a);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
